uart_tx_arbiter: RTL and testbench

//  Shares one uart_transmission instance between N_REQ byte-stream requesters (e.g. CPU TX FIFO, debug

---
 rtl/uart_tx_arbiter_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM states, default sizes and width helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} uart_arb_state_t;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_BURST_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the transmitter start/clear/busy handshake
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   i_req_valid;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_last;
  logic [N_REQ-1:0]   o_req_ready;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               i_tx_clear;
  logic               i_tx_busy;
  modport master (input i_req_valid, i_req_data, i_req_last, i_tx_clear, i_tx_busy,
                  output o_req_ready, o_tx_data, o_tx_start);
  modport slave (output i_req_valid, i_req_data, i_req_last, i_tx_clear, i_tx_busy,
                 input o_req_ready, o_tx_data, o_tx_start);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: first active request after ptr in circular order, as one-hot and index
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // scan farthest-to-nearest so the nearest request after ptr is the one left standing
  always_comb begin
    int k;
    k = 0;
    idx_o = '0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (req_i[k]) idx_o = IW'(k);
    end
    gnt_o = req_i[idx_o] ? (N'(1) << idx_o) : '0;
  end
  assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among N_REQ byte streams
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  uart_tx_arbiter_if.master  bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int BW = cnt_w(MAX_BURST);

  uart_arb_state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, pick_gnt, ready;
  logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [BW-1:0]    burst_q, burst_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d, start_q, start_d, first_q, first_d, busy_q, busy_d;
  logic             pick_any, at_limit;

  uart_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i(bus.i_req_valid),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  assign at_limit = (MAX_BURST != 0) && (int'(burst_q) == MAX_BURST);

  // next-state: arbitrate in IDLE, take one byte in LOAD, hold start until cleared, wait out the frame
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    data_d  = data_q;
    last_d  = last_q;
    start_d = start_q;
    first_d = 1'b0;
    ready   = '0;
    case (state_q)
      IDLE: if (i_enable && pick_any) begin
        grant_d = pick_gnt;
        owner_d = pick_idx;
        burst_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        ready = grant_q & bus.i_req_valid;
        if (|ready) begin
          data_d  = bus.i_req_data[{owner_q, 3'b000} +: 8];
          last_d  = bus.i_req_last[owner_q];
          burst_d = burst_q + BW'(1);
          start_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: if (bus.i_tx_clear) begin
        start_d = 1'b0;
        first_d = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (!first_q && !bus.i_tx_busy) begin
        if (last_q || at_limit) begin
          ptr_d   = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  // state and registered outputs; reset parks the pointer so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      burst_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      last_q  <= last_d;
      start_q <= start_d;
      first_q <= first_d;
      busy_q  <= busy_d;
    end
  end

  assign o_grant         = grant_q;
  assign o_busy          = busy_q;
  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = data_q;
  assign bus.o_tx_start  = start_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the arbiter against a packet-level model
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int D  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] grant;
  logic busy;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_enable(en),
    .o_grant(grant),
    .o_busy(busy),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  logic [8:0] rmem [N][D];
  int rh [N];
  int rt [N];
  int mh [N];
  int stall [N];
  logic [11:0] exp_q [$];
  int log_q [$];
  int m_ptr = N - 1;
  logic clr_real = 1'b0;
  logic prev_start = 1'b0;
  logic rand_stall = 1'b0;
  logic rand_en = 1'b0;
  logic [7:0] held = 8'h00;
  int cl_wait = 0;
  int bz_wait = 0;
  int bz_len = 0;
  int fix_cl = -1;
  int fix_bz = -1;
  int fix_bd = -1;
  int t_clr = 0;
  int t_start = 0;
  logic [N-1:0] rdy_s = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic last);
    rmem[k][rt[k]] = {last, b};
    rt[k]++;
  endtask

  task automatic load_pkt(input int k, input int len);
    for (int i = 0; i < len; i++) push(k, 8'($urandom), i == len - 1);
  endtask

  // packet-level reference: rotate over requesters with data, each grant carries bytes until last or MB
  task automatic predict();
    int pick;
    int cnt;
    logic [8:0] e;
    logic eog;
    while (1) begin
      pick = -1;
      for (int i = 1; i <= N; i++) if (pick < 0 && mh[(m_ptr + i) % N] < rt[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
      if (pick < 0) break;
      cnt = 0;
      eog = 1'b0;
      while (!eog) begin
        e = rmem[pick][mh[pick]];
        mh[pick]++;
        cnt++;
        eog = e[8] || cnt == MB || mh[pick] == rt[pick];
        exp_q.push_back({eog, 3'(pick), e[7:0]});
      end
      m_ptr = pick;
    end
  endtask

  function automatic logic idle_all();
    logic r;
    r = exp_q.size() == 0 && !busy && !bus.o_tx_start && bz_wait == 0 && bz_len == 0;
    for (int k = 0; k < N; k++) if (rh[k] != rt[k]) r = 1'b0;
    return r;
  endfunction

  // one clock: observe after the edge, run transmitter and requester models, then sample ready
  task automatic cyc();
    logic [11:0] e;
    @(posedge clk);
    #1;
    cyc_n++;
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    if (clr_real) begin
      chk("start_drop_on_clear", 32'(bus.o_tx_start), 0);
      t_clr = cyc_n;
      bz_wait = fix_bd >= 0 ? fix_bd : int'($urandom_range(0, 1));
      bz_len = fix_bz >= 0 ? fix_bz : int'($urandom_range(0, 4));
    end
    if (bus.o_tx_start && !prev_start) begin
      t_start = cyc_n;
      chk("busy_at_start", 32'(busy), 1);
      chk("tx_busy_low_before_load", 32'(bus.i_tx_busy), 0);
      if (exp_q.size() == 0) chk("tx_expected_pending", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(bus.o_tx_data), 32'(e[7:0]));
        chk("tx_grant", 32'(grant), 32'(1) << e[10:8]);
        log_q.push_back(int'(e[10:8]));
        if (rand_stall && !e[11] && $urandom_range(0, 2) == 0) stall[int'(e[10:8])] = int'($urandom_range(1, 20));
      end
      held = bus.o_tx_data;
      cl_wait = fix_cl >= 0 ? fix_cl : int'($urandom_range(0, 3));
    end else if (bus.o_tx_start) begin
      chk("tx_data_stable", 32'(bus.o_tx_data), 32'(held));
    end
    prev_start = bus.o_tx_start;
    clr_real = 1'b0;
    bus.i_tx_clear = 1'b0;
    if (bus.o_tx_start) begin
      if (cl_wait == 0) begin
        bus.i_tx_clear = 1'b1;
        clr_real = 1'b1;
      end else cl_wait--;
    end else if (bz_wait == 0 && bz_len == 0 && $urandom_range(0, 7) == 0) bus.i_tx_clear = 1'b1;
    if (bz_wait > 0) begin
      bus.i_tx_busy = 1'b0;
      bz_wait--;
    end else if (bz_len > 0) begin
      bus.i_tx_busy = 1'b1;
      bz_len--;
    end else bus.i_tx_busy = 1'b0;
    if (rand_en) en = $urandom_range(0, 3) != 0;
    for (int k = 0; k < N; k++) begin
      if (stall[k] > 0) stall[k]--;
      bus.i_req_valid[k] = rh[k] < rt[k] && stall[k] == 0;
      bus.i_req_data[8*k +: 8] = rh[k] < rt[k] ? rmem[k][rh[k]][7:0] : 8'h00;
      bus.i_req_last[k] = rh[k] < rt[k] ? rmem[k][rh[k]][8] : 1'b0;
    end
    #1;
    rdy_s = bus.o_req_ready;
    chk("ready_owner_only", 32'(rdy_s & ~(grant & bus.i_req_valid)), 0);
    for (int k = 0; k < N; k++) if (bus.i_req_valid[k] && rdy_s[k]) rh[k]++;
  endtask

  task automatic run_done(input string tag);
    int b;
    b = 0;
    while (!idle_all() && b < 3000) begin
      cyc();
      b++;
    end
    chk({tag, "_completes"}, 32'(b < 3000), 1);
  endtask

  initial begin
    int b;
    int c0;
    bus.i_req_valid = '0;
    bus.i_req_data = '0;
    bus.i_req_last = '0;
    bus.i_tx_clear = 1'b0;
    bus.i_tx_busy = 1'b0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_start", 32'(bus.o_tx_start), 0);
    chk("rst_data", 32'(bus.o_tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.o_req_ready), 0);
    rst_n = 1'b1;
    en = 1'b1;

    load_pkt(0, 1); load_pkt(1, 1); load_pkt(2, 1); load_pkt(0, 1);
    predict();
    log_q.delete();
    run_done("rr3");
    chk("rr3_count", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      chk("rr3_g0", 32'(log_q[0]), 0);
      chk("rr3_g1", 32'(log_q[1]), 1);
      chk("rr3_g2", 32'(log_q[2]), 2);
      chk("rr3_g3", 32'(log_q[3]), 0);
    end

    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    predict();
    log_q.delete();
    cyc();
    chk("lat_c0_grant", 32'(grant), 0);
    cyc();
    chk("lat_c1_grant", 32'(grant), 1);
    chk("lat_c1_ready", 32'(rdy_s), 1);
    chk("lat_c1_start", 32'(bus.o_tx_start), 0);
    cyc();
    chk("lat_c2_start", 32'(bus.o_tx_start), 1);
    chk("lat_c2_data", 32'(bus.o_tx_data), 32'h41);
    run_done("pkt3");
    chk("pkt3_count", 32'(log_q.size()), 3);
    chk("pkt3_grant_drop", 32'(grant), 0);

    load_pkt(1, 10); load_pkt(2, 2);
    predict();
    log_q.delete();
    run_done("burst");
    chk("burst_count", 32'(log_q.size()), 12);
    if (log_q.size() == 12) begin
      chk("burst_b3_req1", 32'(log_q[3]), 1);
      chk("burst_b4_req2", 32'(log_q[4]), 2);
      chk("burst_b6_req1", 32'(log_q[6]), 1);
    end

    load_pkt(0, 3);
    predict();
    log_q.delete();
    b = 0;
    while (!bus.o_tx_start && b < 50) begin cyc(); b++; end
    chk("stall_first_start", 32'(bus.o_tx_start), 1);
    stall[0] = 22;
    load_pkt(3, 2);
    predict();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("stall_lock_held", 32'(grant), 1);
    end
    run_done("stall");
    chk("stall_count", 32'(log_q.size()), 5);
    if (log_q.size() == 5) chk("stall_req3_after", 32'(log_q[3]), 3);

    en = 1'b0;
    fix_cl = 0; fix_bd = 0; fix_bz = 3;
    load_pkt(2, 2);
    predict();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("en_low_no_grant", 32'(grant), 0);
    end
    en = 1'b1;
    cyc();
    chk("en_high_grant", 32'(grant), 32'b0100);
    c0 = t_clr;
    b = 0;
    while (t_clr == c0 && b < 50) begin cyc(); b++; end
    c0 = t_clr;
    b = 0;
    while (t_start <= c0 && b < 50) begin cyc(); b++; end
    chk("busy_hold_gap", 32'(t_start - c0), 5);
    run_done("busy");
    fix_cl = -1; fix_bd = -1; fix_bz = -1;

    load_pkt(1, 3);
    predict();
    b = 0;
    while (!bus.o_tx_start && b < 50) begin cyc(); b++; end
    chk("rst_send_start", 32'(bus.o_tx_start), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_start", 32'(bus.o_tx_start), 0);
    chk("rst_async_grant", 32'(grant), 0);
    chk("rst_async_busy", 32'(busy), 0);
    for (int k = 0; k < N; k++) begin rh[k] = 0; rt[k] = 0; mh[k] = 0; stall[k] = 0; end
    exp_q.delete();
    m_ptr = N - 1;
    clr_real = 1'b0; prev_start = 1'b0; bz_wait = 0; bz_len = 0;
    bus.i_req_valid = '0; bus.i_tx_clear = 1'b0; bus.i_tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_pkt(1, 1); load_pkt(0, 1);
    predict();
    log_q.delete();
    run_done("after_rst");
    if (log_q.size() > 0) chk("after_rst_req0_first", 32'(log_q[0]), 0);
    else chk("after_rst_count", 32'(log_q.size()), 2);

    rand_stall = 1'b1;
    rand_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) for (int p = 0; p < 3; p++) load_pkt(k, int'($urandom_range(1, 6)));
      predict();
      run_done("random");
    end
    rand_en = 1'b0;
    en = 1'b1;
    chk("final_idle_grant", 32'(grant), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
